zigzag_quant_stream: RTL and testbench

Quantiser stage directly downstream of the fdct_zigzag reorder buffer in jpeg_encoder. It consumes the zigzag-ordered 12-bit DCT coefficient stream, 64 per block, and scales each coefficient by a per-position reciprocal from a loadable 64-entry table. It rounds and saturates each result to 11 bits and forwards it with block-boundary flags to the entropy/RLE stage. Valid/ready handshakes are used on both sides.

---
 rtl/zigzag_quant_pkg.sv | 22 ++
 rtl/zigzag_quant_stream_table.sv | 27 ++
 rtl/zigzag_quant_stream.sv | 124 ++++++++++++
 tb/tb_zigzag_quant_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_quant_pkg.sv
// Shared widths, constants and the S1 payload type for the zigzag quantiser stage.
package zigzag_quant_pkg;
  localparam int COEF_W    = 12;
  localparam int OUT_W     = 11;
  localparam int RECIP_W   = 17;
  localparam int BLOCK_LEN = 64;
  localparam int POS_W     = 6;
  localparam int PROD_W    = COEF_W + RECIP_W;
  localparam int Q_W       = PROD_W - 16;

  localparam logic [RECIP_W-1:0] RECIP_ONE = 17'h10000;
  localparam int OUT_MAX    = 1023;
  localparam int OUT_MIN    = -1024;
  localparam int ROUND_HALF = 32768;

  typedef struct packed {
    logic               sign;
    logic [COEF_W-1:0]  mag;
    logic [POS_W-1:0]   pos;
    logic [RECIP_W-1:0] recip;
  } stage_t;
endpackage

// File: rtl/zigzag_quant_stream_table.sv
// 64-entry reciprocal register file: one write port, one combinational read port.
module quant_recip_table
  import zigzag_quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [POS_W-1:0]   i_waddr,
  input  logic [RECIP_W-1:0] i_wdata,
  input  logic [POS_W-1:0]   i_raddr,
  output logic [RECIP_W-1:0] o_rdata
);
  logic [RECIP_W-1:0] r_mem [BLOCK_LEN];

  // Table storage; reset returns every entry to unity gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCK_LEN; i++) begin
        r_mem[i] <= RECIP_ONE;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/zigzag_quant_stream.sv
// Two-stage quantiser: S1 captures magnitude/sign/position/reciprocal, S2 holds the
// rounded, saturated coefficient with its block-boundary flags.
module zigzag_quant_stream
  import zigzag_quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEF_W-1:0]  in_coef,
  input  logic               tbl_we,
  input  logic [5:0]         tbl_addr,
  input  logic [RECIP_W-1:0] tbl_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_coef,
  output logic               out_sob,
  output logic               out_eob
);
  logic [POS_W-1:0]   r_pos;
  logic               r_s1_valid;
  stage_t             r_s1;
  logic               r_s2_valid;
  logic [OUT_W-1:0]   r_s2_coef;
  logic               r_s2_sob;
  logic               r_s2_eob;

  logic               w_adv;
  logic               w_accept;
  logic               w_in_sign;
  logic [COEF_W-1:0]  w_in_mag;
  logic [RECIP_W-1:0] w_recip;
  logic [PROD_W-1:0]  w_prod;
  logic [PROD_W-1:0]  w_rnd;
  logic [Q_W-1:0]     w_q;
  logic [Q_W-1:0]     w_lim;
  logic [Q_W-1:0]     w_qs;
  logic [Q_W-1:0]     w_neg;
  logic [OUT_W-1:0]   w_out;

  assign w_adv     = !r_s2_valid || out_ready;
  assign in_ready  = w_adv && !restart;
  assign w_accept  = in_valid && in_ready;
  assign w_in_sign = in_coef[COEF_W-1];
  // -(-2048) wraps to 12'h800, which is exactly the unsigned magnitude 2048.
  assign w_in_mag  = w_in_sign ? (~in_coef + {{(COEF_W-1){1'b0}}, 1'b1}) : in_coef;

  quant_recip_table u_table (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (tbl_we),
    .i_waddr (tbl_addr),
    .i_wdata (tbl_data),
    .i_raddr (r_pos),
    .o_rdata (w_recip)
  );

  // Scale, round half away from zero in magnitude, then clamp to the signed output range.
  always_comb begin
    w_prod = PROD_W'(r_s1.mag) * PROD_W'(r_s1.recip);
    w_rnd  = w_prod + PROD_W'(ROUND_HALF);
    w_q    = w_rnd[PROD_W-1:16];
    if (r_s1.sign) begin
      w_lim = Q_W'(-OUT_MIN);
    end else begin
      w_lim = Q_W'(OUT_MAX);
    end
    if (w_q > w_lim) begin
      w_qs = w_lim;
    end else begin
      w_qs = w_q;
    end
    w_neg = {Q_W{1'b0}} - w_qs;
    if (r_s1.sign) begin
      w_out = w_neg[OUT_W-1:0];
    end else begin
      w_out = w_qs[OUT_W-1:0];
    end
  end

  // Zigzag position counter; travels with each accepted coefficient.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos <= {POS_W{1'b0}};
    end else if (restart) begin
      r_pos <= {POS_W{1'b0}};
    end else if (w_accept) begin
      r_pos <= r_pos + {{(POS_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline registers; both stages freeze together when the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_coef  <= {OUT_W{1'b0}};
      r_s2_sob   <= 1'b0;
      r_s2_eob   <= 1'b0;
    end else if (restart) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_coef  <= {OUT_W{1'b0}};
      r_s2_sob   <= 1'b0;
      r_s2_eob   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1 <= '{sign: w_in_sign, mag: w_in_mag, pos: r_pos, recip: w_recip};
      end
      r_s2_valid <= r_s1_valid;
      r_s2_coef  <= r_s1_valid ? w_out : {OUT_W{1'b0}};
      r_s2_sob   <= r_s1_valid && (r_s1.pos == {POS_W{1'b0}});
      r_s2_eob   <= r_s1_valid && (r_s1.pos == POS_W'(BLOCK_LEN - 1));
    end
  end

  assign out_valid = r_s2_valid;
  assign out_coef  = r_s2_coef;
  assign out_sob   = r_s2_sob;
  assign out_eob   = r_s2_eob;
endmodule

// File: tb/tb_zigzag_quant_stream.sv
// Directed bench for zigzag_quant_stream: latency, rounding, saturation, flags, stall, restart, reset.
module tb_zigzag_quant_stream;
  import zigzag_quant_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               restart;
  logic               in_valid;
  logic               in_ready;
  logic [COEF_W-1:0]  in_coef;
  logic               tbl_we;
  logic [5:0]         tbl_addr;
  logic [RECIP_W-1:0] tbl_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_coef;
  logic               out_sob;
  logic               out_eob;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [OUT_W-1:0] coef;
    logic             sob;
    logic             eob;
  } obs_t;
  obs_t q_obs[$];

  always #5 clk = ~clk;

  zigzag_quant_stream dut (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_sob(out_sob), .out_eob(out_eob)
  );

  // Record every completed output transfer.
  always @(posedge clk) begin
    if (out_valid && out_ready) q_obs.push_back('{coef: out_coef, sob: out_sob, eob: out_eob});
  end

  function automatic logic [OUT_W-1:0] model(input logic signed [COEF_W-1:0] c, input longint r);
    longint m;
    longint q;
    m = (c < 0) ? -longint'(c) : longint'(c);
    q = (m * r + 32768) >>> 16;
    if (c < 0) begin
      if (q > 1024) q = 1024;
      return OUT_W'(-q);
    end
    if (q > 1023) q = 1023;
    return OUT_W'(q);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart;
    in_valid = 1'b0;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_coef !== 11'd0) begin n_fail++; $display("FAIL reset_coef got %0h exp 0", out_coef); end
    n_checks++; if ({out_sob, out_eob} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {out_sob, out_eob}); end
    #9;
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_unity;
    in_valid = 1'b1; in_coef = 12'd1000;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unity_latency got valid %b exp 0", out_valid); end
    in_coef = 12'hFFF;
    tick();
    n_checks++; if ({out_valid, out_coef, out_sob} !== {1'b1, 11'd1000, 1'b1}) begin n_fail++; $display("FAIL unity_1000 got v%b %0d sob%b exp v1 1000 sob1", out_valid, out_coef, out_sob); end
    in_coef = 12'd0;
    tick();
    n_checks++; if ({out_valid, out_coef, out_sob} !== {1'b1, 11'h7FF, 1'b0}) begin n_fail++; $display("FAIL unity_m1 got v%b %0h sob%b exp v1 7ff sob0", out_valid, out_coef, out_sob); end
    in_coef = 12'h800;
    tick();
    n_checks++; if ({out_valid, out_coef} !== {1'b1, 11'd0}) begin n_fail++; $display("FAIL unity_zero got v%b %0h exp v1 0", out_valid, out_coef); end
    in_coef = 12'd2047;
    tick();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_coef} !== {1'b1, 11'h400}) begin n_fail++; $display("FAIL sat_neg got v%b %0h exp v1 400", out_valid, out_coef); end
    tick();
    n_checks++; if ({out_valid, out_coef} !== {1'b1, 11'h3FF}) begin n_fail++; $display("FAIL sat_pos got v%b %0h exp v1 3ff", out_valid, out_coef); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unity_drain got valid %b exp 0", out_valid); end
  endtask

  task automatic test_q16;
    logic [COEF_W-1:0] vin [4];
    logic [OUT_W-1:0]  vexp [4];
    vin[0] = 12'd100;  vexp[0] = 11'd6;
    vin[1] = 12'hFE8;  vexp[1] = 11'h7FE;
    vin[2] = 12'd8;    vexp[2] = 11'd1;
    vin[3] = 12'hFF9;  vexp[3] = 11'd0;
    tbl_we = 1'b1; tbl_data = 17'd4096;
    for (int a = 0; a < 64; a++) begin
      tbl_addr = 6'(a);
      tick();
    end
    tbl_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      in_coef  = (i < 4) ? vin[i] : 12'd0;
      tick();
      if (i >= 1) begin
        n_checks++;
        if ({out_valid, out_coef} !== {1'b1, vexp[i-1]}) begin
          n_fail++; $display("FAIL q16_%0d got v%b %0h exp v1 %0h", i - 1, out_valid, out_coef, vexp[i-1]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int bubbles;
    int ready_low;
    obs_t e;
    logic signed [COEF_W-1:0] v;
    bubbles = 0; ready_low = 0;
    do_restart();
    q_obs.delete();
    for (int i = 0; i < 132; i++) begin
      in_valid = (i < 130);
      in_coef  = 12'(i * 29 - 1800);
      #1;
      if (i < 130 && in_ready !== 1'b1) ready_low++;
      tick();
      if (i >= 1 && i < 131 && out_valid !== 1'b1) bubbles++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (bubbles != 0 || ready_low != 0) begin n_fail++; $display("FAIL b2b_bubbles got %0d/%0d exp 0/0", bubbles, ready_low); end
    n_checks++; if (q_obs.size() != 130) begin n_fail++; $display("FAIL b2b_count got %0d exp 130", q_obs.size()); end
    for (int i = 0; i < 130 && i < q_obs.size(); i++) begin
      v = 12'(i * 29 - 1800);
      e = '{coef: model(v, 4096), sob: (i % 64 == 0), eob: (i % 64 == 63)};
      n_checks++;
      if (q_obs[i] !== e) begin n_fail++; $display("FAIL b2b_item%0d got %0h/%b%b exp %0h/%b%b", i, q_obs[i].coef, q_obs[i].sob, q_obs[i].eob, e.coef, e.sob, e.eob); end
    end
  endtask

  task automatic test_stall;
    int idx;
    logic acc;
    logic [OUT_W-1:0] held;
    logic signed [COEF_W-1:0] v;
    idx = 0; held = '0;
    q_obs.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 8 && cyc < 13);
      in_valid  = (idx < 20);
      in_coef   = 12'(idx * 113 - 1000);
      #1;
      acc = in_valid && in_ready;
      if (cyc == 8) held = out_coef;
      if (cyc >= 8 && cyc < 13) begin
        n_checks++;
        if ({in_ready, out_valid, out_coef} !== {1'b0, 1'b1, held}) begin
          n_fail++; $display("FAIL stall_cyc%0d got rdy%b v%b %0h exp rdy0 v1 %0h", cyc, in_ready, out_valid, out_coef, held);
        end
      end
      tick();
      if (acc) idx++;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    n_checks++; if (q_obs.size() != 20) begin n_fail++; $display("FAIL stall_count got %0d exp 20", q_obs.size()); end
    for (int i = 0; i < 20 && i < q_obs.size(); i++) begin
      v = 12'(i * 113 - 1000);
      n_checks++;
      if (q_obs[i].coef !== model(v, 4096)) begin n_fail++; $display("FAIL stall_item%0d got %0h exp %0h", i, q_obs[i].coef, model(v, 4096)); end
    end
  endtask

  task automatic test_tbl_same_cycle;
    logic [OUT_W-1:0] ex;
    do_restart();
    q_obs.delete();
    tbl_addr = 6'd5; tbl_data = 17'h10000;
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1; in_coef = 12'd100;
      tbl_we = (i == 5);
      tick();
    end
    tbl_we = 1'b0; in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (q_obs.size() != 70) begin n_fail++; $display("FAIL tbl_count got %0d exp 70", q_obs.size()); end
    for (int i = 0; i < 70 && i < q_obs.size(); i++) begin
      ex = (i == 69) ? 11'd100 : 11'd6;
      n_checks++;
      if (q_obs[i].coef !== ex) begin n_fail++; $display("FAIL tbl_item%0d got %0d exp %0d", i, q_obs[i].coef, ex); end
    end
  endtask

  task automatic test_restart;
    do_restart();
    q_obs.delete();
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_coef = 12'(i + 1);
      tick();
    end
    in_coef = 12'd500; restart = 1'b1; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL restart_in_ready got %b exp 0", in_ready); end
    tick();
    restart = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    n_checks++; if ({out_valid, out_sob, out_eob} !== 3'b000) begin n_fail++; $display("FAIL restart_flush got %b exp 000", {out_valid, out_sob, out_eob}); end
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0 || q_obs.size() != 28) begin n_fail++; $display("FAIL restart_drop got v%b cnt %0d exp v0 cnt 28", out_valid, q_obs.size()); end
    in_valid = 1'b1; in_coef = 12'd100;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if ({out_valid, out_sob, out_coef} !== {1'b1, 1'b1, 11'd6}) begin n_fail++; $display("FAIL restart_sob got v%b sob%b %0d exp v1 sob1 6", out_valid, out_sob, out_coef); end
    tick();
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_coef = 12'd300;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({out_valid, out_coef, out_sob, out_eob} !== {1'b0, 11'd0, 2'b00}) begin n_fail++; $display("FAIL arst_now got v%b %0h exp v0 0", out_valid, out_coef); end
    tick(); tick();
    rst = 1'b1;
    tick();
    in_valid = 1'b1; in_coef = 12'd1000;
    tick();
    in_coef = 12'hFF9;
    tick();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_sob, out_coef} !== {1'b1, 1'b1, 11'd1000}) begin n_fail++; $display("FAIL arst_unity0 got v%b sob%b %0d exp v1 sob1 1000", out_valid, out_sob, out_coef); end
    tick();
    n_checks++; if ({out_valid, out_coef} !== {1'b1, 11'h7F9}) begin n_fail++; $display("FAIL arst_unity1 got v%b %0h exp v1 7f9", out_valid, out_coef); end
    tick();
  endtask

  initial begin
    rst = 1'b0; restart = 1'b0; in_valid = 1'b0; in_coef = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; out_ready = 1'b1;
    test_reset();
    test_unity();
    test_q16();
    test_back_to_back();
    test_stall();
    test_tbl_same_cycle();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "timeout");
  end
endmodule
